// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - 8-digit multiplexed seven-segment scan controller
// Hex values load directly; decimal values go through a 32-step double dabble first.
module sevenseg_scan_ctrl #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        dec_mode,
  input  logic        blank_lz,
  input  logic        value_valid,
  output logic        value_ready,
  output logic        overflow,
  output logic [3:0]  BCD_out,
  output logic [7:0]  anode
);

  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] bin_q;
  logic [31:0] bcd_q;
  logic [31:0] bcd_adj;
  logic [31:0] bcd_shift;
  logic [4:0]  bit_cnt;
  logic        ovf_pend;
  logic        blank_pend;
  logic [31:0] disp_q;
  logic [7:0]  en_q;
  logic [7:0]  nz;
  logic [7:0]  lz_mask;
  logic [DIV_W-1:0] div_q;
  logic [2:0]  idx_q;

  always_comb begin
    state_nxt   = state;
    value_ready = 1'b0;
    case (state)
      IDLE: begin
        value_ready = 1'b1;
        if (value_valid && dec_mode) state_nxt = CONVERT;
      end
      CONVERT: if (bit_cnt == 5'd31) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
  // Digits above the eighth are dropped; values that would need them are flagged as overflow.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[30:0], bin_q[31]};
  end

  // A digit is lit when it or any more significant digit is nonzero; digit 0 is always lit.
  always_comb begin
    nz      = '0;
    lz_mask = '0;
    for (int i = 0; i < 8; i++) nz[i] = (bcd_q[4*i +: 4] != 4'd0);
    for (int i = 0; i < 8; i++) lz_mask[i] = |(nz >> i);
    lz_mask[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      bit_cnt    <= '0;
      ovf_pend   <= 1'b0;
      blank_pend <= 1'b0;
      overflow   <= 1'b0;
      disp_q     <= '0;
      en_q       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (value_valid) begin
            if (dec_mode) begin
              bin_q      <= value_in;
              bcd_q      <= '0;
              bit_cnt    <= '0;
              ovf_pend   <= (value_in > 32'd99_999_999);
              blank_pend <= blank_lz;
            end else begin
              disp_q   <= value_in;
              en_q     <= 8'hFF;
              overflow <= 1'b0;
            end
          end
        end
        CONVERT: begin
          bin_q   <= {bin_q[30:0], 1'b0};
          bcd_q   <= bcd_shift;
          bit_cnt <= bit_cnt + 5'd1;
        end
        COMMIT: begin
          overflow <= ovf_pend;
          if (ovf_pend) begin
            disp_q <= 32'hEEEE_EEEE;
            en_q   <= 8'hFF;
          end else begin
            disp_q <= bcd_q;
            en_q   <= blank_pend ? lz_mask : 8'hFF;
          end
        end
        default: ;
      endcase
    end
  end

  // Scan runs free of the conversion FSM so an accept never disturbs the refresh phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= '0;
      BCD_out <= 4'h0;
      anode   <= 8'hFF;
    end else begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (en_q[idx_q]) begin
        BCD_out <= disp_q[{idx_q, 2'b00} +: 4];
        anode   <= ~(8'h01 << idx_q);
      end else begin
        BCD_out <= 4'h0;
        anode   <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - self-checking bench for sevenseg_scan_ctrl
// Vector table, directed corner sequences and a randomized run against a reference model.
module tb_sevenseg_scan_ctrl;

  localparam int D  = 4;
  localparam int D2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value_in;
  logic        dec_mode, blank_lz, value_valid;
  logic        value_ready, overflow;
  logic [3:0]  bcd;
  logic [7:0]  anode;

  logic        v2_valid;
  logic        r2, o2;
  logic [3:0]  bcd2;
  logic [7:0]  an2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dec_mode(dec_mode), .blank_lz(blank_lz),
    .value_valid(value_valid), .value_ready(value_ready), .overflow(overflow),
    .BCD_out(bcd), .anode(anode)
  );

  sevenseg_scan_ctrl #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .rst(rst), .value_in(32'h7654_3210), .dec_mode(1'b0), .blank_lz(1'b0),
    .value_valid(v2_valid), .value_ready(r2), .overflow(o2),
    .BCD_out(bcd2), .anode(an2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dec_digits(input logic [31:0] v);
    logic [31:0] r;
    longint unsigned p;
    r = '0;
    p = 1;
    if (v > 32'd99_999_999) return 32'hEEEE_EEEE;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'((longint'(v) / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] dec_mask(input logic [31:0] v, input logic blank);
    logic [7:0] m;
    longint unsigned p;
    if (v > 32'd99_999_999 || !blank) return 8'hFF;
    m = '0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      if ((longint'(v) / p) != 0) m[i] = 1'b1;
      p = p * 10;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  function automatic int idx_of(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a == ~(8'h01 << i)) return i;
    return -1;
  endfunction

  // Reference model: latency counter plus arithmetic digit extraction
  logic [31:0] m_disp, p_disp;
  logic [7:0]  m_en, p_en, m_anode;
  logic        m_ovf, p_ovf;
  logic [3:0]  m_bcd;
  int          m_busy;
  int unsigned m_t;
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (rst) begin
      m_t     <= 0;
      m_busy  <= 0;
      m_disp  <= '0;
      m_en    <= '0;
      m_ovf   <= 1'b0;
      m_anode <= 8'hFF;
      m_bcd   <= 4'h0;
    end else begin
      m_t <= m_t + 1;
      if (m_en[(m_t / D) % 8]) begin
        m_anode <= ~(8'h01 << ((m_t / D) % 8));
        m_bcd   <= m_disp[4*((m_t / D) % 8) +: 4];
      end else begin
        m_anode <= 8'hFF;
        m_bcd   <= 4'h0;
      end
      if (m_busy == 0) begin
        if (value_valid) begin
          if (!dec_mode) begin
            m_disp <= value_in;
            m_en   <= 8'hFF;
            m_ovf  <= 1'b0;
          end else begin
            m_busy <= 33;
            p_disp <= dec_digits(value_in);
            p_en   <= dec_mask(value_in, blank_lz);
            p_ovf  <= (value_in > 32'd99_999_999);
          end
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_disp <= p_disp;
          m_en   <= p_en;
          m_ovf  <= p_ovf;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_ready", {31'd0, value_ready}, {31'd0, m_busy == 0});
      check("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("model_anode", {24'd0, anode}, {24'd0, m_anode});
      check("model_bcd", {28'd0, bcd}, {28'd0, m_bcd});
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!value_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'd0, value_ready}, 32'd1);
  endtask

  task automatic send(input logic dec, input logic blank, input logic [31:0] v);
    wait_ready();
    value_in    = v;
    dec_mode    = dec;
    blank_lz    = blank;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] digs, output logic [7:0] mask);
    digs = '0;
    mask = '0;
    repeat (8 * D) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if (anode == ~(8'h01 << i)) digs[4*i +: 4] = bcd;
      mask = mask | ~anode;
    end
  endtask

  typedef struct {
    string       name;
    logic        dec;
    logic        blank;
    logic [31:0] val;
    logic [31:0] exp_digits;
    logic [7:0]  exp_mask;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] digs;
    logic [7:0]  mask;
    int          n, prev, cur, changes, wraps, skips;

    vecs[0] = '{"hex_1234abcd", 1'b0, 1'b0, 32'h1234_ABCD, 32'h1234_ABCD, 8'hFF, 1'b0};
    vecs[1] = '{"dec_12345678", 1'b1, 1'b0, 32'd12345678,  32'h1234_5678, 8'hFF, 1'b0};
    vecs[2] = '{"dec_42_blank", 1'b1, 1'b1, 32'd42,        32'h0000_0042, 8'h03, 1'b0};
    vecs[3] = '{"dec_0_blank",  1'b1, 1'b1, 32'd0,         32'h0000_0000, 8'h01, 1'b0};
    vecs[4] = '{"dec_1e8_ovf",  1'b1, 1'b1, 32'd100000000, 32'hEEEE_EEEE, 8'hFF, 1'b1};
    vecs[5] = '{"hex_0_clear",  1'b0, 1'b0, 32'h0,         32'h0000_0000, 8'hFF, 1'b0};
    vecs[6] = '{"dec_max",      1'b1, 1'b1, 32'd99999999,  32'h9999_9999, 8'hFF, 1'b0};
    vecs[7] = '{"dec_1000",     1'b1, 1'b1, 32'd1000,      32'h0000_1000, 8'h0F, 1'b0};
    vecs[8] = '{"dec_42_noblk", 1'b1, 1'b0, 32'd42,        32'h0000_0042, 8'hFF, 1'b0};
    vecs[9] = '{"dec_ffff_ovf", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 8'hFF, 1'b1};

    rst = 1'b1; value_in = '0; dec_mode = 1'b0; blank_lz = 1'b0; value_valid = 1'b0; v2_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_anode", {24'd0, anode}, 32'hFF);
    check("rst_bcd", {28'd0, bcd}, 32'h0);
    check("rst_ready", {31'd0, value_ready}, 32'd1);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      send(vecs[k].dec, vecs[k].blank, vecs[k].val);
      wait_ready();
      repeat (D + 1) @(negedge clk);
      collect(digs, mask);
      check({vecs[k].name, "_digits"}, digs, vecs[k].exp_digits);
      check({vecs[k].name, "_mask"}, {24'd0, mask}, {24'd0, vecs[k].exp_mask});
      check({vecs[k].name, "_ovf"}, {31'd0, overflow}, {31'd0, vecs[k].exp_ovf});
    end

    // Decimal busy window length
    send(1'b1, 1'b0, 32'd12345678);
    n = 0;
    while (!value_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("dec_busy_cycles", n, 33);

    // value_valid held through a conversion: the hex value lands exactly once at N+34
    wait_ready();
    value_in = 32'd5; dec_mode = 1'b1; blank_lz = 1'b0; value_valid = 1'b1;
    @(negedge clk);
    value_in = 32'hCAFE_F00D; dec_mode = 1'b0;
    n = 0;
    while (!value_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    value_valid = 1'b0;
    check("held_busy_cycles", n, 33);
    repeat (D + 1) @(negedge clk);
    collect(digs, mask);
    check("held_digits", digs, 32'hCAFE_F00D);
    check("held_mask", {24'd0, mask}, 32'hFF);

    // Reset at N+10 aborts conversion and blanks the display
    send(1'b0, 1'b0, 32'h8765_4321);
    send(1'b1, 1'b0, 32'd11);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_anode", {24'd0, anode}, 32'hFF);
    check("abort_ready", {31'd0, value_ready}, 32'd1);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    collect(digs, mask);
    check("abort_mask", {24'd0, mask}, 32'h0);
    check("abort_digits", digs, 32'h0);

    // Randomized traffic checked by the model
    for (int k = 0; k < 1500; k++) begin
      value_valid = ($urandom % 4 == 0);
      dec_mode    = $urandom % 2;
      blank_lz    = $urandom % 2;
      case ($urandom % 4)
        0: value_in = $urandom % 1000;
        1: value_in = 32'd99999990 + ($urandom % 20);
        2: value_in = $urandom;
        default: value_in = $urandom % 100000000;
      endcase
      rst = ($urandom % 400 == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    value_valid = 1'b0;

    // Scan wrap with CLK_DIV = 2
    v2_valid = 1'b1;
    @(negedge clk);
    v2_valid = 1'b0;
    repeat (4) @(negedge clk);
    prev = idx_of(an2);
    changes = 0; wraps = 0; skips = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      cur = idx_of(an2);
      if (cur != prev) begin
        changes++;
        if (cur != (prev + 1) % 8) skips++;
        if (prev == 7 && cur == 0) wraps++;
      end
      prev = cur;
    end
    check("wrap_changes", changes, 32);
    check("wrap_count", wraps, 4);
    check("wrap_skips", skips, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, meaning clock cycles each digit is lit (range 2..2^20).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port value_in  input  32  value to display.
REQ-005 SHALL have port dec_mode  input  1  1 = decimal display, 0 = hex display; sampled with value_in.
REQ-006 SHALL have port blank_lz  input  1  1 = blank leading zero digits in decimal mode.
REQ-007 SHALL have port value_valid  input  1  value_in/dec_mode/blank_lz are valid this cycle.
REQ-008 SHALL have port value_ready  output  1  block accepts a value this cycle.
REQ-009 SHALL have port overflow  output  1  last decimal value exceeded 99_999_999.
REQ-010 SHALL have port BCD_out  output  4  nibble of the currently lit digit, for the downstream seven-segment decoder.
REQ-011 SHALL have port anode  output  8  digit enables, active-low; bit i = digit i, digit 0 rightmost.

Function
REQ-012 SHALL accept a value on any edge where value_valid && value_ready; SHALL ignore value_valid while value_ready is 0, with no buffering.
REQ-013 SHALL implement states IDLE, CONVERT, COMMIT. value_ready SHALL be 1 only in IDLE.
REQ-014 Hex accept (dec_mode = 0) SHALL stay in IDLE and load digit i = value_in[4i+3:4i] into the display register on the accept edge. All 8 digits SHALL be enabled. overflow SHALL clear.
REQ-015 Decimal accept SHALL go IDLE->CONVERT. On accept edge N, CONVERT SHALL run shift-add-3 (double dabble) over 32 bits on edges N+1..N+32, then go to COMMIT.
REQ-016 COMMIT (edge N+33) SHALL write the 8 BCD digits to the display register and return to IDLE. value_ready SHALL be 1 from cycle N+34.
REQ-017 Decimal value > 99_999_999 SHALL set overflow = 1 at COMMIT, load all 8 digits with 4'hE, and disable leading-zero blanking.
REQ-018 Decimal with blank_lz = 1 SHALL disable digits 7..1 above the most significant nonzero digit. Digit 0 SHALL always be enabled (value 0 shows "0").
REQ-019 The display register and digit-enable mask SHALL change only on a hex accept edge or a COMMIT edge. The old display SHALL persist during CONVERT.
REQ-020 The scan divider SHALL count 0..CLK_DIV-1 and wrap. On the wrap edge the digit index SHALL advance 0->1->...->7->0.
REQ-021 BCD_out and anode SHALL be registered and reflect the digit index with one-cycle latency. anode[idx] = 0 only if digit idx is enabled; all other bits = 1.
REQ-022 A disabled digit SHALL present BCD_out = 4'h0 with its anode high.
REQ-023 The scan SHALL run continuously and independently of the conversion FSM; an accept SHALL NOT reset the divider or index.

Reset
REQ-024 While rst = 1 on an edge: state = IDLE, value_ready = 1, overflow = 0, display digits = 0, enable mask = 8'h00, divider = 0, index = 0, BCD_out = 4'h0, anode = 8'hFF.
REQ-025 Reset during CONVERT or COMMIT SHALL abort the conversion without writing the display register, leaving the reset values of REQ-024.
REQ-026 value_valid SHALL be ignored on an edge where rst = 1.

Verification
REQ-027 Hex: CLK_DIV = 4, accept 32'h1234ABCD -> over 32 cycles anode walks FE,FD,...,7F with BCD_out D,C,B,A,4,3,2,1; value_ready stays 1.
REQ-028 Decimal: accept 12345678 at edge N -> value_ready 0 on cycles N+1..N+33, 1 at N+34; digits 8,7,6,5,4,3,2,1; overflow 0.
REQ-029 Blanking: decimal 42 with blank_lz = 1 -> only anode bits 0,1 ever go low; BCD_out 2 then 4. Decimal 0 -> only digit 0 lit, showing 0.
REQ-030 Overflow: decimal 100_000_000 -> overflow 1, all 8 digits 4'hE, all anodes cycle; a following hex accept clears overflow.
REQ-031 Handshake and reset: value_valid held during CONVERT -> ignored, accepted once at N+34. rst asserted at N+10 -> next cycle anode = FF, value_ready = 1, and the previous display does not reappear.
REQ-032 Wrap: CLK_DIV = 2, idle 16 cycles -> index wraps 7->0 exactly once per 16 cycles with no skipped digit.
